// File: rtl/frv_masked_b2a_seq.sv
// frv_masked_b2a_seq: first-order Boolean-to-arithmetic mask conversion (Goubin), one register stage per step.
module frv_masked_b2a_seq #(
   parameter int BIT_WIDTH = 32
) (
   input  logic                 g_clk,
   input  logic                 g_reset,
   input  logic                 flush,
   input  logic                 valid,
   input  logic [BIT_WIDTH-1:0] rs_s0,
   input  logic [BIT_WIDTH-1:0] rs_s1,
   input  logic [BIT_WIDTH-1:0] z0,
   input  logic [BIT_WIDTH-1:0] z1,
   output logic [BIT_WIDTH-1:0] rd_s0,
   output logic [BIT_WIDTH-1:0] rd_s1,
   output logic                 ready,
   output logic                 busy
);
   typedef enum logic [2:0] {IDLE, MASK, SUB, MIX, DONE} state_t;
   state_t state, nxt;
   logic ld1, ld2, ld3, ld4;
   logic [BIT_WIDTH-1:0] xp1, t0, g1, t1, rg1, r1;
   logic [BIT_WIDTH-1:0] d0, d1, xp2, r2, g2, rg2;
   logic [BIT_WIDTH-1:0] m, d1_3, r3, g3, rg3;
   logic [BIT_WIDTH-1:0] rd0_q, rd1_q;
   always_comb begin
      nxt = IDLE;
      if (!flush)
         case (state)
            IDLE:    nxt = valid ? MASK : IDLE;
            MASK:    nxt = valid ? SUB  : IDLE;
            SUB:     nxt = valid ? MIX  : IDLE;
            MIX:     nxt = valid ? DONE : IDLE;
            default: nxt = IDLE;
         endcase
   end
   // each stage register loads only on entry to its own state and is zero otherwise
   assign ld1 = !g_reset && nxt == MASK;
   assign ld2 = !g_reset && nxt == SUB;
   assign ld3 = !g_reset && nxt == MIX;
   assign ld4 = !g_reset && nxt == DONE;
   always_ff @(posedge g_clk) begin
      state <= g_reset ? IDLE : nxt;
      xp1   <= ld1 ? rs_s0                : '0;
      t0    <= ld1 ? rs_s0 ^ z0           : '0;
      g1    <= ld1 ? z0                   : '0;
      t1    <= ld1 ? rs_s0 ^ (rs_s1 ^ z0) : '0;
      rg1   <= ld1 ? rs_s1 ^ z0           : '0;
      r1    <= ld1 ? z1                   : '0;
      d0    <= ld2 ? t0 - g1              : '0;
      d1    <= ld2 ? t1 - rg1             : '0;
      xp2   <= ld2 ? xp1                  : '0;
      r2    <= ld2 ? r1                   : '0;
      g2    <= ld2 ? g1                   : '0;
      rg2   <= ld2 ? rg1                  : '0;
      m     <= ld3 ? d0 ^ xp2             : '0;
      d1_3  <= ld3 ? d1                   : '0;
      r3    <= ld3 ? r2                   : '0;
      g3    <= ld3 ? g2                   : '0;
      rg3   <= ld3 ? rg2                  : '0;
      // the mask r is only unmasked inside this combinational step, never in a register
      rd0_q <= ld4 ? (m ^ d1_3) + r3      : '0;
      rd1_q <= ld4 ? r3 - (rg3 ^ g3)      : '0;
   end
   assign ready = state == DONE;
   assign busy  = state != IDLE;
   assign rd_s0 = ready ? rd0_q : '0;
   assign rd_s1 = ready ? rd1_q : '0;
endmodule

// File: tb/tb_frv_masked_b2a_seq.sv
// tb_frv_masked_b2a_seq: directed vector table plus abort, reset and back-to-back sequences.
module tb_frv_masked_b2a_seq;
   logic g_clk, g_reset, flush, valid, ready, busy;
   logic [31:0] rs_s0, rs_s1, z0, z1, rd_s0, rd_s1;
   int errs = 0, checks = 0;

   frv_masked_b2a_seq #(.BIT_WIDTH(32)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .valid(valid),
      .rs_s0(rs_s0), .rs_s1(rs_s1), .z0(z0), .z1(z1),
      .rd_s0(rd_s0), .rd_s1(rd_s1), .ready(ready), .busy(busy)
   );

   initial g_clk = 0;
   always #5 g_clk = ~g_clk;

   typedef struct {
      logic [31:0] s0, s1, z0, z1, e0, e1;
   } vec_t;
   vec_t tv[5];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // starts at a negedge in IDLE; returns at the negedge where ready is seen (lat=0 on timeout)
   task automatic run_op(input logic [31:0] s0, s1, zz0, zz1,
                         output logic [31:0] o0, o1, output int lat, output logic b1);
      rs_s0 = s0; rs_s1 = s1; z0 = zz0; z1 = zz1; valid = 1;
      @(posedge g_clk);
      lat = 0; o0 = 0; o1 = 0; b1 = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge g_clk);
         if (n == 1) b1 = busy;
         if (ready) begin
            lat = n; o0 = rd_s0; o1 = rd_s1;
            break;
         end
         rs_s0 = $urandom; rs_s1 = $urandom; z0 = $urandom; z1 = $urandom;
      end
   endtask

   task automatic watch(input string name, input int n);
      int seen = 0;
      repeat (n) begin
         @(negedge g_clk);
         if (ready) seen++;
      end
      chk(name, seen, 0);
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_busy"}, {31'd0, busy}, 0);
      chk({name, "_ready"}, {31'd0, ready}, 0);
      chk({name, "_rd0"}, rd_s0, 0);
      chk({name, "_rd1"}, rd_s1, 0);
   endtask

   initial begin
      logic [31:0] o0, o1, a, b;
      int lat;
      logic b1;
      tv[0] = '{32'h000000F0, 32'h0000000F, 32'h12345678, 32'h00000010, 32'h00000100, 32'h00000001};
      tv[1] = '{32'h00000000, 32'h00000001, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
      tv[2] = '{32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF};
      tv[3] = '{32'h12345678, 32'h00000000, 32'h0F0F0F0F, 32'h00000000, 32'h12345678, 32'h00000000};
      tv[4] = '{32'h00000000, 32'hFFFFFFFF, 32'h33333333, 32'h00000005, 32'h00000005, 32'h00000006};
      g_reset = 1; flush = 0; valid = 0; rs_s0 = 0; rs_s1 = 0; z0 = 0; z1 = 0;
      repeat (2) @(negedge g_clk);
      chk_idle("reset");
      g_reset = 0;
      @(negedge g_clk);

      foreach (tv[i]) begin
         run_op(tv[i].s0, tv[i].s1, tv[i].z0, tv[i].z1, o0, o1, lat, b1);
         chk("latency", lat, 4);
         chk("busy_mask", {31'd0, b1}, 1);
         chk("vec_rd0", o0, tv[i].e0);
         chk("vec_rd1", o1, tv[i].e1);
         @(negedge g_clk);
         chk_idle("after_done");
         valid = 0;
      end

      for (int i = 0; i < 1000; i++) begin
         run_op(32'hFFFFFFFF, 32'h0, $urandom, 32'hFFFFFFFF, o0, o1, lat, b1);
         chk("z0_rd0", o0, 32'hFFFFFFFE);
         chk("z0_rd1", o1, 32'hFFFFFFFF);
         @(negedge g_clk);
      end
      valid = 0;
      @(negedge g_clk);

      // flush in SUB
      rs_s0 = tv[0].s0; rs_s1 = tv[0].s1; z0 = tv[0].z0; z1 = tv[0].z1; valid = 1;
      repeat (2) @(negedge g_clk);
      chk("flush_in_sub_busy", {31'd0, busy}, 1);
      flush = 1;
      @(negedge g_clk);
      chk_idle("flush_sub");
      flush = 0; valid = 0;
      watch("flush_no_ready", 6);

      // flush beats valid in IDLE
      valid = 1; flush = 1;
      @(negedge g_clk);
      chk("flush_prio_busy", {31'd0, busy}, 0);
      flush = 0; valid = 0;
      @(negedge g_clk);

      // valid dropped in MIX
      valid = 1;
      repeat (3) @(negedge g_clk);
      chk("mix_busy", {31'd0, busy}, 1);
      valid = 0;
      @(negedge g_clk);
      chk_idle("valid_drop_mix");
      watch("drop_no_ready", 6);

      // reset during MASK
      valid = 1;
      @(negedge g_clk);
      g_reset = 1; valid = 0;
      @(negedge g_clk);
      g_reset = 0;
      chk_idle("reset_mask");
      watch("reset_no_ready", 6);
      run_op(tv[0].s0, tv[0].s1, tv[0].z0, tv[0].z1, o0, o1, lat, b1);
      chk("post_reset_rd0", o0, 32'h00000100);
      chk("post_reset_rd1", o1, 32'h00000001);

      // valid held through DONE: pass through IDLE, recapture 5 cycles after first capture
      @(negedge g_clk);
      chk_idle("b2b_idle");
      rs_s0 = tv[0].s0; rs_s1 = tv[0].s1; z0 = tv[0].z0; z1 = tv[0].z1;
      @(negedge g_clk);
      chk("b2b_recapture_busy", {31'd0, busy}, 1);
      chk("b2b_ready_low", {31'd0, ready}, 0);
      repeat (3) @(negedge g_clk);
      chk("b2b_ready", {31'd0, ready}, 1);
      chk("b2b_rd0", rd_s0, 32'h00000100);
      chk("b2b_rd1", rd_s1, 32'h00000001);
      @(negedge g_clk);

      for (int i = 0; i < 10000; i++) begin
         a = $urandom; b = $urandom;
         run_op(a, b, $urandom, $urandom, o0, o1, lat, b1);
         chk("rand_diff", o0 - o1, a ^ b);
         @(negedge g_clk);
      end
      valid = 0;
      @(negedge g_clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
